hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Parametrised hazard-detection and forwarding controller for the 5-stage pipeline, generalising the fixed 4-register, 2-cycle-flush unit. Combines load-use and DMA bus-loss stall detection, a configurable-depth flush sequencer for control redirects, symmetric MEM/WB forwarding for both operands, and optional stall/flush performance counters. Sits beside the datapath and drives the IF/ID, ID/EX and EX/MEM enables, the PC mux and the forwarding muxes.

## Interface
- REG_AW, 2: register-index width.
- FLUSH_DEPTH, 2: bubble cycles after the redirect cycle, 1..7.
- HAS_ZERO_REG, 0: 1 means register 0 is hardwired and never matches for forwarding or load-use.
- CNT_W, 16: perf counter width.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ic_miss, dc_miss, halted  in  1 each  I-cache miss, D-cache miss, halt.
- mem_grant  in  1  pipeline owns memory bus; 0 means DMA holds it.
- id_rs, id_rt  in  REG_AW each; id_use_rs, id_use_rt  in  1 each.
- ex_valid, ex_is_load, ex_branch_taken, ex_is_jump, ex_is_jr  in  1 each.
- ex_rs, ex_rt  in  REG_AW each; ex_use_rs, ex_use_rt  in  1 each.
- mem_valid, mem_reg_write  in  1 each; mem_wr_reg  in  REG_AW.
- wb_valid, wb_reg_write  in  1 each; wb_wr_reg  in  REG_AW.
- ic_read, pc_write, ifid_write, idex_write, exmem_write, bubble  out  1 each.
- pc_src  out  2  00 seq, 01 branch, 10 jr, 11 jump.
- fwd_a, fwd_b  out  2 each  00 regfile, 01 WB, 10 MEM.
- load_stalled  out  1  registered: previous cycle stalled.
- flush_active  out  1  flush counter non-zero.
- stall_cycles, flush_events  out  CNT_W each  perf counters.

## Operation
- match(a,b) = (a==b) and not (HAS_ZERO_REG and a==0).
- load_use = ex_valid & ex_is_load & ((id_use_rs & match(id_rs,ex_rt)) | (id_use_rt & match(id_rt,ex_rt))).
- stall = !mem_grant | load_use.
- redirect = ex_valid & (ex_branch_taken | ex_is_jump | ex_is_jr).
- pc_src priority: branch_taken, then jr, then jump; 00 if !ex_valid.
- ic_read = !ic_miss. idex_write = exmem_write = !dc_miss.
- ifid_write = !halted & !stall & !ic_miss & !dc_miss.
- pc_write = (!ic_miss & !dc_miss & !halted & !stall) | (redirect & !dc_miss).
- flush_cnt (3 bits): loads FLUSH_DEPTH when redirect & !dc_miss; else decrements when non-zero and !dc_miss; holds during dc_miss.
- bubble = stall | redirect | flush_active.
- fwd_a = 10 if mem_valid & mem_reg_write & ex_use_rs & match(ex_rs,mem_wr_reg); else 01 on same WB condition; else 00. fwd_b identical using ex_use_rt/ex_rt. MEM beats WB.
- load_stalled <= stall each cycle.

## Timing
- All outputs except load_stalled, flush_active and counters are combinational, same cycle.
- Redirect in cycle T: bubble high T through T+FLUSH_DEPTH with no dc_miss; each dc_miss cycle extends the window by one.
- Redirect while flush_cnt non-zero reloads FLUSH_DEPTH.
- Reset (reset_n low at an edge): flush_cnt=0, load_stalled=0, counters=0. Mid-flush reset clears flush_active on that edge.
- Simultaneous stall and redirect: pc_write=1 (redirect wins), ifid_write=0, bubble=1.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cycles increments each cycle ifid_write==0 & !halted.
  - flush_events increments each cycle redirect & !dc_miss.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Load to r2 in EX, ID uses rs=r2: stall=1, pc_write=0, ifid_write=0, bubble=1. Next cycle load_stalled=1.
- Taken branch at T, FLUSH_DEPTH=2: pc_src=01, pc_write=1, bubble high T..T+2, flush_active low at T+3.
- Redirect at T with dc_miss at T+1: flush_active holds for one cycle, and bubble drops one cycle later than without the miss.
- MEM and WB both write r1, EX rs=rt=r1: fwd_a=fwd_b=10. Drop mem_reg_write: both 01.
- HAS_ZERO_REG=1, load to r0, ID uses r0: no stall. MEM writes r0: fwd_a=00.
- HAZ_PERF_CNT_EN, CNT_W=4, 20 cycles with mem_grant=0: stall_cycles=15 (saturated). Reset then clears it to 0.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl_if
// Description : Bundle of the pipeline status inputs and control outputs that
//               connect the hazard/forwarding controller to the datapath.
//               slave  : used by hazard_fwd_ctrl (status in, controls out)
//               master : used by the datapath side / testbench driver
// Parameters  : REG_AW - register-index width
//               CNT_W  - performance counter width
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_fwd_ctrl_if #(
    parameter int REG_AW = 2,
    parameter int CNT_W  = 16
);
    // front-end / memory status
    logic              ic_miss;
    logic              dc_miss;
    logic              halted;
    logic              mem_grant;
    // decode stage operands
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    // execute stage
    logic              ex_valid;
    logic              ex_is_load;
    logic              ex_branch_taken;
    logic              ex_is_jump;
    logic              ex_is_jr;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_use_rs;
    logic              ex_use_rt;
    // memory and writeback producers
    logic              mem_valid;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_wr_reg;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_wr_reg;
    // controls
    logic              ic_read;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              exmem_write;
    logic              bubble;
    logic [1:0]        pc_src;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              load_stalled;
    logic              flush_active;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    modport slave (
        input  ic_miss, dc_miss, halted, mem_grant,
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_valid, ex_is_load, ex_branch_taken, ex_is_jump, ex_is_jr,
        input  ex_rs, ex_rt, ex_use_rs, ex_use_rt,
        input  mem_valid, mem_reg_write, mem_wr_reg,
        input  wb_valid, wb_reg_write, wb_wr_reg,
        output ic_read, pc_write, ifid_write, idex_write, exmem_write, bubble,
        output pc_src, fwd_a, fwd_b, load_stalled, flush_active,
        output stall_cycles, flush_events
    );

    modport master (
        output ic_miss, dc_miss, halted, mem_grant,
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_valid, ex_is_load, ex_branch_taken, ex_is_jump, ex_is_jr,
        output ex_rs, ex_rt, ex_use_rs, ex_use_rt,
        output mem_valid, mem_reg_write, mem_wr_reg,
        output wb_valid, wb_reg_write, wb_wr_reg,
        input  ic_read, pc_write, ifid_write, idex_write, exmem_write, bubble,
        input  pc_src, fwd_a, fwd_b, load_stalled, flush_active,
        input  stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : Hazard detection and forwarding control for a 5-stage
//               pipeline: load-use / DMA bus-loss stalls, a flush sequencer
//               that inserts FLUSH_DEPTH bubbles after a control redirect,
//               MEM/WB operand forwarding and optional perf counters.
// Ports       : clk     - clock, all state on rising edge
//               reset_n - synchronous active-low reset
//               bus     - hazard_fwd_ctrl_if.slave (pipeline status in,
//                         enables / pc_src / forwarding selects out)
// Config      : `define HAZ_PERF_CNT_EN to build the saturating
//               stall_cycles / flush_events counters; otherwise both read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int REG_AW       = 2,
    parameter int FLUSH_DEPTH  = 2,   // 1..7
    parameter int HAS_ZERO_REG = 0,
    parameter int CNT_W        = 16
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    hazard_fwd_ctrl_if.slave   bus
);

    localparam logic [2:0] c_flush_depth = 3'(FLUSH_DEPTH);

    // Register comparison; a hardwired r0 never creates a dependence.
    function automatic logic f_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
        return (a == b) && !((HAS_ZERO_REG != 0) && (a == '0));
    endfunction

    logic       w_load_use;
    logic       w_stall;
    logic       w_redirect;
    logic       w_ifid_write;
    logic       w_flush_active;
    logic [2:0] r_flush_cnt;
    logic       r_load_stalled;

    assign w_load_use = bus.ex_valid && bus.ex_is_load &&
                        ((bus.id_use_rs && f_match(bus.id_rs, bus.ex_rt)) ||
                         (bus.id_use_rt && f_match(bus.id_rt, bus.ex_rt)));
    assign w_stall    = !bus.mem_grant || w_load_use;
    assign w_redirect = bus.ex_valid &&
                        (bus.ex_branch_taken || bus.ex_is_jump || bus.ex_is_jr);
    assign w_ifid_write   = !bus.halted && !w_stall && !bus.ic_miss && !bus.dc_miss;
    assign w_flush_active = (r_flush_cnt != 3'd0);

    // Flush sequencer: a redirect (re)loads the bubble count; a D-cache miss
    // freezes the pipe, so the count holds and the window stretches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flush_cnt    <= 3'd0;
            r_load_stalled <= 1'b0;
        end else begin
            r_load_stalled <= w_stall;
            if (w_redirect && !bus.dc_miss) begin
                r_flush_cnt <= c_flush_depth;
            end else if (w_flush_active && !bus.dc_miss) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        bus.ic_read     = !bus.ic_miss;
        bus.idex_write  = !bus.dc_miss;
        bus.exmem_write = !bus.dc_miss;
        bus.ifid_write  = w_ifid_write;
        // The redirect target must be captured even while the front end stalls.
        bus.pc_write    = w_ifid_write || (w_redirect && !bus.dc_miss);
        bus.bubble      = w_stall || w_redirect || w_flush_active;

        bus.pc_src = 2'b00;
        if (bus.ex_valid) begin
            if (bus.ex_branch_taken) begin
                bus.pc_src = 2'b01;
            end else if (bus.ex_is_jr) begin
                bus.pc_src = 2'b10;
            end else if (bus.ex_is_jump) begin
                bus.pc_src = 2'b11;
            end
        end

        // MEM holds the younger result, so it is checked before WB.
        bus.fwd_a = 2'b00;
        if (bus.ex_use_rs && bus.mem_valid && bus.mem_reg_write &&
            f_match(bus.ex_rs, bus.mem_wr_reg)) begin
            bus.fwd_a = 2'b10;
        end else if (bus.ex_use_rs && bus.wb_valid && bus.wb_reg_write &&
                     f_match(bus.ex_rs, bus.wb_wr_reg)) begin
            bus.fwd_a = 2'b01;
        end

        bus.fwd_b = 2'b00;
        if (bus.ex_use_rt && bus.mem_valid && bus.mem_reg_write &&
            f_match(bus.ex_rt, bus.mem_wr_reg)) begin
            bus.fwd_b = 2'b10;
        end else if (bus.ex_use_rt && bus.wb_valid && bus.wb_reg_write &&
                     f_match(bus.ex_rt, bus.wb_wr_reg)) begin
            bus.fwd_b = 2'b01;
        end
    end

    assign bus.load_stalled = r_load_stalled;
    assign bus.flush_active = w_flush_active;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Saturating counters: they stick at all-ones until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_ifid_write && !bus.halted && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_redirect && !bus.dc_miss && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_ctrl
// Description : Scoreboard bench for hazard_fwd_ctrl. Two instances share the
//               same stimulus: one with HAS_ZERO_REG=0, one with
//               HAS_ZERO_REG=1. Counter expectations follow HAZ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    localparam int c_aw    = 2;
    localparam int c_depth = 2;
    localparam int c_cw    = 4;
    localparam int c_cmax  = (1 << c_cw) - 1;
`ifdef HAZ_PERF_CNT_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    typedef struct {
        bit       reset_n, ic_miss, dc_miss, halted, mem_grant;
        bit [1:0] id_rs, id_rt;
        bit       id_use_rs, id_use_rt;
        bit       ex_valid, ex_is_load, ex_branch_taken, ex_is_jump, ex_is_jr;
        bit [1:0] ex_rs, ex_rt;
        bit       ex_use_rs, ex_use_rt;
        bit       mem_valid, mem_reg_write;
        bit [1:0] mem_wr_reg;
        bit       wb_valid, wb_reg_write;
        bit [1:0] wb_wr_reg;
    } stim_t;

    typedef struct {
        int flush_left;
        bit prev_stall;
        int stalls;
        int flushes;
    } mstate_t;

    typedef struct {
        bit       check_state;
        int       cyc;
        bit       ic_read, pc_write, ifid_write, idex_write, exmem_write, bubble;
        bit [1:0] pc_src, fwd_a, fwd_b;
        bit       load_stalled, flush_active;
        int       stall_cycles, flush_events;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.REG_AW(c_aw), .CNT_W(c_cw)) u_if  ();
    hazard_fwd_ctrl_if #(.REG_AW(c_aw), .CNT_W(c_cw)) u_ifz ();

    hazard_fwd_ctrl #(.REG_AW(c_aw), .FLUSH_DEPTH(c_depth), .HAS_ZERO_REG(0), .CNT_W(c_cw))
        dut (.clk(clk), .reset_n(reset_n), .bus(u_if));
    hazard_fwd_ctrl #(.REG_AW(c_aw), .FLUSH_DEPTH(c_depth), .HAS_ZERO_REG(1), .CNT_W(c_cw))
        dut_z (.clk(clk), .reset_n(reset_n), .bus(u_ifz));

    exp_t    q0[$];
    exp_t    q1[$];
    mstate_t m0, m1;
    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    bit      first    = 1'b1;

    // ---------------- reference model ----------------
    function automatic bit same(bit [1:0] a, bit [1:0] b, bit zero);
        return (a == b) && !(zero && a == 2'd0);
    endfunction

    function automatic bit is_stall(stim_t s, bit zero);
        bit dep;
        dep = (s.id_use_rs && same(s.id_rs, s.ex_rt, zero)) ||
              (s.id_use_rt && same(s.id_rt, s.ex_rt, zero));
        return !s.mem_grant || (s.ex_valid && s.ex_is_load && dep);
    endfunction

    function automatic bit is_redirect(stim_t s);
        return s.ex_valid && (s.ex_branch_taken || s.ex_is_jump || s.ex_is_jr);
    endfunction

    // Source of an EX operand: the youngest in-flight writer of that register.
    function automatic bit [1:0] source_of(stim_t s, bit used, bit [1:0] r, bit zero);
        if (!used) return 2'd0;
        if (s.mem_valid && s.mem_reg_write && same(r, s.mem_wr_reg, zero)) return 2'd2;
        if (s.wb_valid && s.wb_reg_write && same(r, s.wb_wr_reg, zero)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic exp_t predict(stim_t s, mstate_t m, bit zero, bit chk, int c);
        exp_t e;
        bit   frontend_ok;
        e.check_state  = chk;
        e.cyc          = c;
        frontend_ok    = !s.halted && !s.ic_miss && !s.dc_miss && !is_stall(s, zero);
        e.ic_read      = !s.ic_miss;
        e.idex_write   = !s.dc_miss;
        e.exmem_write  = !s.dc_miss;
        e.ifid_write   = frontend_ok;
        e.pc_write     = frontend_ok || (is_redirect(s) && !s.dc_miss);
        e.bubble       = is_stall(s, zero) || is_redirect(s) || (m.flush_left > 0);
        if (!s.ex_valid)            e.pc_src = 2'd0;
        else if (s.ex_branch_taken) e.pc_src = 2'd1;
        else if (s.ex_is_jr)        e.pc_src = 2'd2;
        else if (s.ex_is_jump)      e.pc_src = 2'd3;
        else                        e.pc_src = 2'd0;
        e.fwd_a        = source_of(s, s.ex_use_rs, s.ex_rs, zero);
        e.fwd_b        = source_of(s, s.ex_use_rt, s.ex_rt, zero);
        e.load_stalled = m.prev_stall;
        e.flush_active = (m.flush_left > 0);
        e.stall_cycles = c_perf ? m.stalls  : 0;
        e.flush_events = c_perf ? m.flushes : 0;
        return e;
    endfunction

    function automatic mstate_t advance(stim_t s, mstate_t m, bit zero, exp_t e);
        mstate_t n;
        if (!s.reset_n) begin
            n.flush_left = 0; n.prev_stall = 1'b0; n.stalls = 0; n.flushes = 0;
            return n;
        end
        n = m;
        n.prev_stall = is_stall(s, zero);
        if (is_redirect(s) && !s.dc_miss) n.flush_left = c_depth;
        else if (m.flush_left > 0 && !s.dc_miss) n.flush_left = m.flush_left - 1;
        if (!e.ifid_write && !s.halted && m.stalls < c_cmax) n.stalls = m.stalls + 1;
        if (is_redirect(s) && !s.dc_miss && m.flushes < c_cmax) n.flushes = m.flushes + 1;
        return n;
    endfunction

    // ---------------- stimulus ----------------
    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        s.reset_n   = 1'b1;
        s.mem_grant = 1'b1;
        return s;
    endfunction

    task automatic put_if(stim_t s);
        reset_n = s.reset_n;
        u_if.ic_miss = s.ic_miss;           u_ifz.ic_miss = s.ic_miss;
        u_if.dc_miss = s.dc_miss;           u_ifz.dc_miss = s.dc_miss;
        u_if.halted = s.halted;             u_ifz.halted = s.halted;
        u_if.mem_grant = s.mem_grant;       u_ifz.mem_grant = s.mem_grant;
        u_if.id_rs = s.id_rs;               u_ifz.id_rs = s.id_rs;
        u_if.id_rt = s.id_rt;               u_ifz.id_rt = s.id_rt;
        u_if.id_use_rs = s.id_use_rs;       u_ifz.id_use_rs = s.id_use_rs;
        u_if.id_use_rt = s.id_use_rt;       u_ifz.id_use_rt = s.id_use_rt;
        u_if.ex_valid = s.ex_valid;         u_ifz.ex_valid = s.ex_valid;
        u_if.ex_is_load = s.ex_is_load;     u_ifz.ex_is_load = s.ex_is_load;
        u_if.ex_branch_taken = s.ex_branch_taken; u_ifz.ex_branch_taken = s.ex_branch_taken;
        u_if.ex_is_jump = s.ex_is_jump;     u_ifz.ex_is_jump = s.ex_is_jump;
        u_if.ex_is_jr = s.ex_is_jr;         u_ifz.ex_is_jr = s.ex_is_jr;
        u_if.ex_rs = s.ex_rs;               u_ifz.ex_rs = s.ex_rs;
        u_if.ex_rt = s.ex_rt;               u_ifz.ex_rt = s.ex_rt;
        u_if.ex_use_rs = s.ex_use_rs;       u_ifz.ex_use_rs = s.ex_use_rs;
        u_if.ex_use_rt = s.ex_use_rt;       u_ifz.ex_use_rt = s.ex_use_rt;
        u_if.mem_valid = s.mem_valid;       u_ifz.mem_valid = s.mem_valid;
        u_if.mem_reg_write = s.mem_reg_write; u_ifz.mem_reg_write = s.mem_reg_write;
        u_if.mem_wr_reg = s.mem_wr_reg;     u_ifz.mem_wr_reg = s.mem_wr_reg;
        u_if.wb_valid = s.wb_valid;         u_ifz.wb_valid = s.wb_valid;
        u_if.wb_reg_write = s.wb_reg_write; u_ifz.wb_reg_write = s.wb_reg_write;
        u_if.wb_wr_reg = s.wb_wr_reg;       u_ifz.wb_wr_reg = s.wb_wr_reg;
    endtask

    // One cycle: drive after the edge, push the expected response, advance model.
    task automatic drive(stim_t s);
        exp_t e0, e1;
        @(posedge clk);
        #1;
        put_if(s);
        e0 = predict(s, m0, 1'b0, !first, cyc);
        e1 = predict(s, m1, 1'b1, !first, cyc);
        q0.push_back(e0);
        q1.push_back(e1);
        m0 = advance(s, m0, 1'b0, e0);
        m1 = advance(s, m1, 1'b1, e1);
        first = 1'b0;
        cyc++;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.reset_n         = ($urandom_range(0, 49) != 0);
        s.ic_miss         = ($urandom_range(0, 9) == 0);
        s.dc_miss         = ($urandom_range(0, 7) == 0);
        s.halted          = ($urandom_range(0, 15) == 0);
        s.mem_grant       = ($urandom_range(0, 7) != 0);
        s.id_rs           = 2'($urandom_range(0, 3));
        s.id_rt           = 2'($urandom_range(0, 3));
        s.id_use_rs       = 1'($urandom);
        s.id_use_rt       = 1'($urandom);
        s.ex_valid        = ($urandom_range(0, 3) != 0);
        s.ex_is_load      = ($urandom_range(0, 2) == 0);
        s.ex_branch_taken = ($urandom_range(0, 5) == 0);
        s.ex_is_jump      = ($urandom_range(0, 7) == 0);
        s.ex_is_jr        = ($urandom_range(0, 7) == 0);
        s.ex_rs           = 2'($urandom_range(0, 3));
        s.ex_rt           = 2'($urandom_range(0, 3));
        s.ex_use_rs       = 1'($urandom);
        s.ex_use_rt       = 1'($urandom);
        s.mem_valid       = 1'($urandom);
        s.mem_reg_write   = 1'($urandom);
        s.mem_wr_reg      = 2'($urandom_range(0, 3));
        s.wb_valid        = 1'($urandom);
        s.wb_reg_write    = 1'($urandom);
        s.wb_wr_reg       = 2'($urandom_range(0, 3));
        return s;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic check(string name, int c, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("ic_read",     e.cyc, 32'(u_if.ic_read),     32'(e.ic_read));
            check("pc_write",    e.cyc, 32'(u_if.pc_write),    32'(e.pc_write));
            check("ifid_write",  e.cyc, 32'(u_if.ifid_write),  32'(e.ifid_write));
            check("idex_write",  e.cyc, 32'(u_if.idex_write),  32'(e.idex_write));
            check("exmem_write", e.cyc, 32'(u_if.exmem_write), 32'(e.exmem_write));
            check("bubble",      e.cyc, 32'(u_if.bubble),      32'(e.bubble));
            check("pc_src",      e.cyc, 32'(u_if.pc_src),      32'(e.pc_src));
            check("fwd_a",       e.cyc, 32'(u_if.fwd_a),       32'(e.fwd_a));
            check("fwd_b",       e.cyc, 32'(u_if.fwd_b),       32'(e.fwd_b));
            if (e.check_state) begin
                check("load_stalled", e.cyc, 32'(u_if.load_stalled), 32'(e.load_stalled));
                check("flush_active", e.cyc, 32'(u_if.flush_active), 32'(e.flush_active));
                check("stall_cycles", e.cyc, 32'(u_if.stall_cycles), 32'(e.stall_cycles));
                check("flush_events", e.cyc, 32'(u_if.flush_events), 32'(e.flush_events));
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("z_pc_write",   e.cyc, 32'(u_ifz.pc_write),   32'(e.pc_write));
            check("z_ifid_write", e.cyc, 32'(u_ifz.ifid_write), 32'(e.ifid_write));
            check("z_bubble",     e.cyc, 32'(u_ifz.bubble),     32'(e.bubble));
            check("z_fwd_a",      e.cyc, 32'(u_ifz.fwd_a),      32'(e.fwd_a));
            check("z_fwd_b",      e.cyc, 32'(u_ifz.fwd_b),      32'(e.fwd_b));
            if (e.check_state) begin
                check("z_load_stalled", e.cyc, 32'(u_ifz.load_stalled), 32'(e.load_stalled));
                check("z_flush_active", e.cyc, 32'(u_ifz.flush_active), 32'(e.flush_active));
                check("z_stall_cycles", e.cyc, 32'(u_ifz.stall_cycles), 32'(e.stall_cycles));
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        stim_t s;
        m0 = '{default: 0};
        m1 = '{default: 0};
        s = idle_stim();
        s.reset_n = 1'b0;
        put_if(s);

        // reset, then idle
        drive(s);
        drive(s);
        drive(idle_stim());

        // load to r2 in EX, ID reads r2 -> stall, then load_stalled
        s = idle_stim();
        s.ex_valid = 1'b1; s.ex_is_load = 1'b1; s.ex_rt = 2'd2;
        s.id_rs = 2'd2; s.id_use_rs = 1'b1;
        drive(s);
        drive(idle_stim());

        // taken branch, bubble window of FLUSH_DEPTH cycles after it
        s = idle_stim();
        s.ex_valid = 1'b1; s.ex_branch_taken = 1'b1;
        drive(s);
        repeat (4) drive(idle_stim());

        // redirect followed by a D-cache miss stretches the window
        drive(s);
        s = idle_stim(); s.dc_miss = 1'b1;
        drive(s);
        repeat (4) drive(idle_stim());

        // reload during flush, and stall + jump in the same cycle
        s = idle_stim(); s.ex_valid = 1'b1; s.ex_is_jr = 1'b1;
        drive(s);
        drive(idle_stim());
        s = idle_stim(); s.ex_valid = 1'b1; s.ex_is_jump = 1'b1; s.mem_grant = 1'b0;
        drive(s);
        repeat (3) drive(idle_stim());

        // MEM and WB both write r1: MEM wins, then WB only
        s = idle_stim();
        s.ex_valid = 1'b1; s.ex_rs = 2'd1; s.ex_rt = 2'd1;
        s.ex_use_rs = 1'b1; s.ex_use_rt = 1'b1;
        s.mem_valid = 1'b1; s.mem_reg_write = 1'b1; s.mem_wr_reg = 2'd1;
        s.wb_valid = 1'b1; s.wb_reg_write = 1'b1; s.wb_wr_reg = 2'd1;
        drive(s);
        s.mem_reg_write = 1'b0;
        drive(s);

        // r0 dependences: only the zero-reg instance ignores them
        s = idle_stim();
        s.ex_valid = 1'b1; s.ex_is_load = 1'b1; s.ex_rt = 2'd0;
        s.id_rs = 2'd0; s.id_use_rs = 1'b1;
        drive(s);
        s = idle_stim();
        s.ex_valid = 1'b1; s.ex_rs = 2'd0; s.ex_use_rs = 1'b1;
        s.mem_valid = 1'b1; s.mem_reg_write = 1'b1; s.mem_wr_reg = 2'd0;
        drive(s);

        // counter saturation: reset, 20 bus-loss cycles, reset again
        s = idle_stim(); s.reset_n = 1'b0;
        drive(s);
        s = idle_stim(); s.mem_grant = 1'b0;
        repeat (20) drive(s);
        drive(idle_stim());
        s = idle_stim(); s.reset_n = 1'b0;
        drive(s);
        drive(idle_stim());

        // randomized traffic
        repeat (600) drive(rand_stim());
        drive(idle_stim());

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", cyc, 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
